// File: rtl/mux4_rr_scheduler_if.sv
// Channel-side and shared-output signals of the 4:1 round-robin scheduler.
// The master side drives the channels; the slave side is the scheduler.
interface mux4_rr_scheduler_if #(
   parameter int DATA_W = 1
);
   logic                  ena;
   logic [3:0]            req;
   logic [3:0]            last;
   logic [4*DATA_W-1:0]   ch_data;
   logic [1:0]            sel;
   logic [3:0]            grant;
   logic                  out_valid;
   logic [DATA_W-1:0]     out_data;
   logic                  busy;
   logic                  timeout;

   modport master (
      output ena, req, last, ch_data,
      input  sel, grant, out_valid, out_data, busy, timeout
   );

   modport slave (
      input  ena, req, last, ch_data,
      output sel, grant, out_valid, out_data, busy, timeout
   );
endinterface

// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner selection for a shared 4:1 datapath, with a per-grant
// hold limit, a one-cycle dead gap between owners and a registered output lane.
module mux4_rr_scheduler #(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   mux4_rr_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t              state;
   logic [1:0]          ptr;
   logic [7:0]          hold_cnt;
   logic [DATA_W-1:0]   lane [4];
   logic                arb_found;
   logic [1:0]          arb_win;
   logic [1:0]          idx;
   logic                hold_at_max;
   logic                grant_end;
   logic                sole_limit;

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         lane[k] = bus.ch_data[k*DATA_W +: DATA_W];
      end
   end

   // First requester at or above the pointer, wrapping modulo 4.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = ptr;
      idx       = ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!arb_found && bus.req[idx]) begin
            arb_found = 1'b1;
            arb_win   = idx;
         end
      end
   end

   assign hold_at_max = (hold_cnt == 8'(MAX_HOLD));
   assign grant_end   = bus.last[bus.sel] | ~bus.req[bus.sel] | ~bus.ena | hold_at_max;
   // The timeout pulse reports only grants cut short purely by the limit.
   assign sole_limit  = hold_at_max & ~bus.last[bus.sel] & bus.req[bus.sel] & bus.ena;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         hold_cnt      <= '0;
         bus.sel       <= '0;
         bus.grant     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.busy      <= 1'b0;
         bus.timeout   <= 1'b0;
      end else begin
         bus.timeout   <= 1'b0;
         bus.out_valid <= 1'b0;
         case (state)
            IDLE, RELEASE: begin
               if (bus.ena && arb_found) begin
                  state     <= GRANT;
                  bus.grant <= 4'b0001 << arb_win;
                  bus.sel   <= arb_win;
                  hold_cnt  <= 8'd1;
                  bus.busy  <= 1'b1;
               end else begin
                  state     <= IDLE;
                  bus.grant <= '0;
                  bus.busy  <= 1'b0;
               end
            end
            GRANT: begin
               bus.out_valid <= 1'b1;
               bus.out_data  <= lane[bus.sel];
               if (grant_end) begin
                  state       <= RELEASE;
                  bus.grant   <= '0;
                  ptr         <= bus.sel + 2'd1;
                  bus.timeout <= sole_limit;
                  bus.busy    <= 1'b1;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               state     <= IDLE;
               bus.grant <= '0;
               bus.busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Scoreboard bench for mux4_rr_scheduler: an ownership-level reference model
// queues expected per-cycle controls and data samples; a monitor checks them.
module tb_mux4_rr_scheduler;

   localparam int DW = 4;
   localparam int MH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux4_rr_scheduler_if #(.DATA_W(DW)) bus ();

   mux4_rr_scheduler #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Expected control word {grant, sel, busy, timeout, out_valid} per edge.
   logic [8:0]    cq [$];
   logic [DW-1:0] dq [$];

   // Reference model: who owns the lane, for how long, and where the search starts.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   int m_sel   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_sel   = 0;
   endtask

   task automatic step();
      logic [3:0] g;
      logic       tmo;
      logic       v;
      logic       rel;
      logic       b;
      logic       lim;
      int         k;
      tmo = 1'b0;
      rel = 1'b0;
      if (!rst_n) begin
         model_reset();
         dq.delete();
         cq.push_back('0);
         return;
      end
      v = (m_owner >= 0);
      if (m_owner >= 0) begin
         k = m_owner;
         dq.push_back(bus.ch_data[k*DW +: DW]);
         lim = (m_held == MH);
         if (bus.last[k] || !bus.req[k] || !bus.ena || lim) begin
            tmo     = lim && !bus.last[k] && bus.req[k] && bus.ena;
            m_ptr   = (k + 1) % 4;
            m_owner = -1;
            rel     = 1'b1;
         end else begin
            m_held++;
         end
      end else if (bus.ena && bus.req != 4'b0) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.req[(m_ptr + i) % 4]) begin
               m_owner = (m_ptr + i) % 4;
               break;
            end
         end
         m_held = 1;
         m_sel  = m_owner;
      end
      g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      b = (m_owner >= 0) || rel;
      cq.push_back({g, 2'(m_sel), b, tmo, v});
   endtask

   task automatic drive(input logic r_n, input logic e, input logic [3:0] r, input logic [3:0] l);
      @(negedge clk);
      rst_n       = r_n;
      bus.ena     = e;
      bus.req     = r;
      bus.last    = l;
      bus.ch_data = 16'($urandom);
      step();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_outputs",
            {bus.grant, bus.sel, bus.busy, bus.timeout, bus.out_valid, bus.out_data}, '0);
      model_reset();
      dq.delete();
      #1 rst_n = 1'b1;
      step();
   endtask

   always @(posedge clk) begin
      logic [8:0] exp_c;
      logic [8:0] act_c;
      logic [DW-1:0] exp_d;
      #1;
      if (cq.size() > 0) begin
         exp_c = cq.pop_front();
         act_c = {bus.grant, bus.sel, bus.busy, bus.timeout, bus.out_valid};
         total++;
         if (act_c !== exp_c) begin
            bad++;
            $display("FAIL ctrl at %0t: got grant=%b sel=%0d busy=%b timeout=%b valid=%b, expected grant=%b sel=%0d busy=%b timeout=%b valid=%b",
                     $time, act_c[8:5], act_c[4:3], act_c[2], act_c[1], act_c[0],
                     exp_c[8:5], exp_c[4:3], exp_c[2], exp_c[1], exp_c[0]);
         end
      end
      if (bus.out_valid === 1'b1) begin
         total++;
         if (dq.size() == 0) begin
            bad++;
            $display("FAIL out_data at %0t: got unexpected sample %0h, expected none", $time, bus.out_data);
         end else begin
            exp_d = dq.pop_front();
            if (bus.out_data !== exp_d) begin
               bad++;
               $display("FAIL out_data at %0t: got %0h, expected %0h", $time, bus.out_data, exp_d);
            end
         end
      end
   end

   initial begin
      bus.ena     = 1'b1;
      bus.req     = 4'hF;
      bus.last    = 4'h0;
      bus.ch_data = '0;

      repeat (3) drive(1'b0, 1'b1, 4'hF, 4'h0);
      repeat (3) drive(1'b1, 1'b1, 4'h0, 4'h0);

      // Single burst on channel 2 ended by last on its third grant cycle.
      drive(1'b1, 1'b1, 4'b0100, 4'h0);
      drive(1'b1, 1'b1, 4'b0100, 4'h0);
      drive(1'b1, 1'b1, 4'b0100, 4'h0);
      drive(1'b1, 1'b1, 4'b0100, 4'b0100);
      repeat (3) drive(1'b1, 1'b1, 4'h0, 4'h0);

      // Fairness from a fresh pointer with every channel requesting.
      repeat (2) drive(1'b0, 1'b1, 4'h0, 4'h0);
      repeat (48) drive(1'b1, 1'b1, 4'hF, 4'h0);
      repeat (2) drive(1'b1, 1'b1, 4'h0, 4'h0);

      // last coinciding with the hold limit on channel 1.
      repeat (14) drive(1'b1, 1'b1, 4'b0010,
                        (m_owner == 1 && m_held == MH) ? 4'b0010 : 4'b0000);
      repeat (2) drive(1'b1, 1'b1, 4'h0, 4'h0);

      // ena drop during channel 3's second grant cycle.
      drive(1'b1, 1'b1, 4'b1000, 4'h0);
      drive(1'b1, 1'b1, 4'b1000, 4'h0);
      drive(1'b1, 1'b0, 4'b1000, 4'h0);
      repeat (4) drive(1'b1, 1'b0, 4'hF, 4'h0);
      repeat (3) drive(1'b1, 1'b1, 4'hF, 4'h0);

      reset_pulse();
      repeat (4) drive(1'b1, 1'b1, 4'hF, 4'h0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_pulse();
         end else begin
            drive(1'b1,
                  $urandom_range(0, 15) != 0,
                  ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
         end
      end

      repeat (3) drive(1'b1, 1'b0, 4'h0, 4'h0);
      repeat (2) @(posedge clk);
      #2;
      check("data_queue_drained", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
